// File: rtl/bcd_pkg.sv
// Purpose : shared types and constants for the sequential binary-to-BCD converter.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_t FSM encoding, DIGIT_W nibble width, SAT_DIGIT, max_bcd() limit.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // Digit value used to fill the output when the input cannot be represented.
  localparam logic [DIGIT_W-1:0] SAT_DIGIT = 4'h9;

  // Largest value representable with 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned max_bcd(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Purpose : start/busy/done conversion bus between a result producer and bin2bcd_seq.
// Latency : n/a (wires only).
// Backpr. : producer may only expect start to be taken while busy is low.
// Ports   : master drives start/bin and observes bcd/busy/done/overflow/neg; slave is the converter.
interface bin2bcd_seq_if #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  neg;

  modport master (
    output start, bin,
    input  bcd, busy, done, overflow, neg
  );

  modport slave (
    input  start, bin,
    output bcd, busy, done, overflow, neg
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Purpose : one double-dabble cell, adds 3 to a BCD digit that is 5 or more.
// Latency : combinational.
// Backpr. : none.
// Ports   : d = digit before shift, q = corrected digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose : sequential shift-add-3 binary to packed BCD converter with saturation.
// Latency : done pulses IN_W cycles after the accepting edge; back-to-back period IN_W+1.
// Backpr. : start is ignored (not queued) while busy; accepted in IDLE or in the FIN cycle.
// Ports   : clk, reset (sync, active high), bus (slave modport: start/bin in,
//           bcd/busy/done/overflow/neg out).
// Option  : `define BCD_SIGNED_EN treats bin as two's complement and reports the sign on neg;
//           without it bin is unsigned and neg is constant 0.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int                BCD_W   = DIGIT_W * DIGITS;
  localparam int                CNT_W   = $clog2(IN_W + 1);
  localparam int unsigned       MAX_VAL = max_bcd(DIGITS);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(IN_W - 1);

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shift_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_pend_q;
  logic               ovf_q;
  logic [IN_W-1:0]    mag;
  logic               accept;
  logic               last_iter;
  logic               carry_unused;

  // Magnitude of the incoming value; the most negative code maps onto itself,
  // which read as unsigned is exactly 2^(IN_W-1).
`ifdef BCD_SIGNED_EN
  logic in_neg;
  logic neg_pend_q;
  logic neg_q;
  assign in_neg = bus.bin[IN_W-1];
  assign mag    = in_neg ? (~bus.bin + 1'b1) : bus.bin;
`else
  assign mag    = bus.bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .q (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit shifted out of the top digit only matters for values that are
  // saturated anyway, so it is dropped.
  assign scratch_nxt  = {adj[BCD_W-2:0], shift_q[IN_W-1]};
  assign carry_unused = adj[BCD_W-1];

  assign accept    = bus.start && (state_q != CONV);
  assign last_iter = (state_q == CONV) && (count_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (count_q == LAST) state_d = FIN;
      FIN:     state_d = bus.start ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        shift_q    <= mag;
        scratch_q  <= '0;
        count_q    <= '0;
        ovf_pend_q <= 32'(mag) > MAX_VAL;
      end else if (state_q == CONV) begin
        shift_q   <= shift_q << 1;
        scratch_q <= scratch_nxt;
        count_q   <= count_q + CNT_W'(1);
      end
      // Results move to the outputs only on the edge entering FIN, using the
      // value produced by the final iteration in the same cycle.
      if (last_iter) begin
        bcd_q <= ovf_pend_q ? {DIGITS{SAT_DIGIT}} : scratch_nxt;
        ovf_q <= ovf_pend_q;
      end
    end
  end

`ifdef BCD_SIGNED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (accept) neg_pend_q <= in_neg;
      if (last_iter) neg_q <= neg_pend_q;
    end
  end
  assign bus.neg = neg_q;
`else
  assign bus.neg = 1'b0;
`endif

  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == CONV);
  assign bus.done     = (state_q == FIN);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Purpose : scoreboard bench for bin2bcd_seq; directed vectors with hand-computed results.
// Latency : checks done arrives 14 cycles after accept and busy lasts 14 cycles.
// Backpr. : exercises start during CONV (ignored) and start held high (period 15).
module tb_bin2bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (q.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("bcd",      32'(bus.bcd),      32'(e.bcd));
            chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("neg",      32'(bus.neg),      32'(e.neg));
            chk("latency",  32'(cyc - e.acc),  32'd14);
            chk("busy_len", 32'(busy_cnt),     32'd14);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Launch one conversion; bin is scrambled right after the accept edge.
  task automatic issue(input logic [13:0] b, input logic [15:0] eb,
                       input logic eo, input logic en, input bit push);
    exp_t e;
    @(posedge clk); #2;
    bus.bin   = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e = '{eb, eo, en, cyc};
      q.push_back(e);
    end
    #1;
    bus.start = 1'b0;
    bus.bin   = 14'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || bus.busy) && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (k >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   a;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd",      32'(bus.bcd),      32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_neg",      32'(bus.neg),      32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    issue(14'd0,     16'h0000, 1'b0, 1'b0, 1'b1); drain();
    issue(14'd1234,  16'h1234, 1'b0, 1'b0, 1'b1); drain();
    issue(14'd9999,  16'h9999, 1'b0, 1'b0, 1'b1); drain();
`ifdef BCD_SIGNED_EN
    issue(14'd10000, 16'h6384, 1'b0, 1'b1, 1'b1); drain();
    issue(14'd16383, 16'h0001, 1'b0, 1'b1, 1'b1); drain();
    issue(14'h2000,  16'h8192, 1'b0, 1'b1, 1'b1); drain();
    issue(14'h3FD6,  16'h0042, 1'b0, 1'b1, 1'b1); drain();
`else
    issue(14'd10000, 16'h9999, 1'b1, 1'b0, 1'b1); drain();
    issue(14'd16383, 16'h9999, 1'b1, 1'b0, 1'b1); drain();
    issue(14'h2000,  16'h8192, 1'b0, 1'b0, 1'b1); drain();
`endif

    // start pulse during CONV must be ignored.
    issue(14'd42, 16'h0042, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #2;
    bus.bin   = 14'd77;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    drain();
    repeat (20) @(posedge clk);

    // start held high: three back-to-back conversions, 15 cycles apart.
    @(posedge clk); #2;
    bus.bin   = 14'd5;
    bus.start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    for (int i = 0; i < 3; i++) begin
      e = '{16'h0005, 1'b0, 1'b0, a + 15 * i};
      q.push_back(e);
    end
    repeat (30) @(posedge clk); #2;
    bus.start = 1'b0;
    drain();

    // Reset in the middle of a conversion: no done, outputs cleared.
    issue(14'd999, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy",     32'(bus.busy),     32'd0);
    chk("abort_bcd",      32'(bus.bcd),      32'd0);
    chk("abort_done",     32'(bus.done),     32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);
    repeat (20) @(posedge clk);

    issue(14'd321, 16'h0321, 1'b0, 1'b0, 1'b1); drain();
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
